// File: rtl/parking_pkg.sv
// Shared types and sensor encodings for the parking-lot entry/exit detector.
// Sensor codes are written {a,b}: a is the outer beam, b the inner beam.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3,
    ERR
  } parking_state_t;

  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;
  localparam logic [1:0] S_B    = 2'b01;

endpackage

// File: rtl/parking_sensor_fsm_if.sv
// Sensor inputs and occupancy-counter pulses of the parking detector.
// The detector is the slave; the sensor/counter side is the master.
interface parking_sensor_fsm_if;

  logic a;
  logic b;
  logic inc;
  logic dec;
  logic err;

  modport master (output a, output b, input inc, input dec, input err);
  modport slave  (input a, input b, output inc, output dec, output err);

endinterface

// File: rtl/sensor_sync.sv
// Multi-flop synchronizer for asynchronous sensor bits; q lags d by DEPTH edges.
// DEPTH is expected to be 2..4.
module sensor_sync #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [DEPTH];

  // NOTE: the whole chain is cleared on reset so a stale pre-reset sensor
  // value can never reach the FSM after reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/parking_sensor_fsm.sv
// Two-beam parking gate detector: emits inc on a completed entry, dec on a
// completed exit, and holds err while an illegal beam sequence is pending.
module parking_sensor_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  parking_sensor_fsm_if.slave  bus
);

  import parking_pkg::*;

  logic [1:0]     ab_raw;
  logic [1:0]     ab_sync;
  parking_state_t state_q;
  parking_state_t state_d;
  logic           inc_d;
  logic           dec_d;
  logic           err_d;
  logic           inc_q;
  logic           dec_q;
  logic           err_q;

  assign ab_raw = {bus.a, bus.b};

  sensor_sync #(
    .WIDTH (2),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ab_raw),
    .q     (ab_sync)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  // An unchanged sensor code matches no arc below and leaves the state alone.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab_sync)
          S_A:     state_d = IN1;
          S_B:     state_d = OUT1;
          S_AB:    state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      IN1: begin
        case (ab_sync)
          S_AB:    state_d = IN2;
          S_NONE:  state_d = IDLE;
          S_B:     state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      IN2: begin
        case (ab_sync)
          S_B:     state_d = IN3;
          S_A:     state_d = IN1;
          S_NONE:  state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      IN3: begin
        case (ab_sync)
          S_NONE: begin
            state_d = IDLE;
            inc_d   = 1'b1;
          end
          S_AB:    state_d = IN2;
          S_A:     state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      OUT1: begin
        case (ab_sync)
          S_AB:    state_d = OUT2;
          S_NONE:  state_d = IDLE;
          S_A:     state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      OUT2: begin
        case (ab_sync)
          S_A:     state_d = OUT3;
          S_B:     state_d = OUT1;
          S_NONE:  state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      OUT3: begin
        case (ab_sync)
          S_NONE: begin
            state_d = IDLE;
            dec_d   = 1'b1;
          end
          S_AB:    state_d = OUT2;
          S_B:     state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      ERR: begin
        if (ab_sync == S_NONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = (state_d == ERR);
  end

  assign bus.inc = inc_q;
  assign bus.dec = dec_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// Scoreboard bench for parking_sensor_fsm: a path-walking reference model
// predicts {inc,dec,err} per driven code; results are compared after the sync delay.
module tb_parking_sensor_fsm;

  import parking_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  parking_sensor_fsm_if sif ();

  parking_sensor_fsm #(
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [2:0] exp_q[$];
  int         m_mode;      // 0 idle, 1 entering, 2 exiting, 3 error
  int         m_step;      // position along the entering/exiting path, 1..3
  int         cnt_inc;
  int         cnt_dec;
  int         occupancy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Code expected at step s of the path; the exit path is the entry path with a/b swapped.
  function automatic logic [1:0] path_code(input int mode, input int s);
    logic [1:0] c;
    case (s)
      1:       c = 2'b10;
      2:       c = 2'b11;
      3:       c = 2'b01;
      default: c = 2'b00;
    endcase
    if (mode == 2) c = {c[0], c[1]};
    return c;
  endfunction

  task automatic model_step(input logic [1:0] code, output logic [2:0] exp);
    int done_dir;
    done_dir = 0;
    if (m_mode == 0) begin
      if (code == 2'b10) begin
        m_mode = 1; m_step = 1;
      end else if (code == 2'b01) begin
        m_mode = 2; m_step = 1;
      end else if (code == 2'b11) begin
        m_mode = 3;
      end
    end else if (m_mode == 3) begin
      if (code == 2'b00) m_mode = 0;
    end else begin
      if (code == path_code(m_mode, m_step)) begin
        m_mode = m_mode;
      end else if (m_step < 3 && code == path_code(m_mode, m_step + 1)) begin
        m_step++;
      end else if (code == 2'b00 && (m_step == 1 || m_step == 3)) begin
        if (m_step == 3) done_dir = m_mode;
        m_mode = 0;
      end else if (m_step > 1 && code == path_code(m_mode, m_step - 1)) begin
        m_step--;
      end else begin
        m_mode = 3;
      end
    end
    exp = {done_dir == 1, done_dir == 2, m_mode == 3};
  endtask

  task automatic drive(input logic [1:0] ab);
    logic [2:0] e;
    sif.a = ab[1];
    sif.b = ab[0];
    model_step(ab, e);
    exp_q.push_back(e);
  endtask

  task automatic observe();
    if (sif.inc === 1'b1) begin cnt_inc++; occupancy++; end
    if (sif.dec === 1'b1) begin cnt_dec++; occupancy--; end
    if (exp_q.size() == SYNC_STAGES + 1)
      check("outs{inc,dec,err}", {29'd0, sif.inc, sif.dec, sif.err}, {29'd0, exp_q.pop_front()});
  endtask

  task automatic step(input logic [1:0] ab);
    @(negedge clk);
    observe();
    drive(ab);
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    repeat (n) step(ab);
  endtask

  task automatic clear_counts();
    cnt_inc   = 0;
    cnt_dec   = 0;
    occupancy = 0;
  endtask

  task automatic apply_reset(input logic [1:0] ab_after);
    @(negedge clk);
    observe();
    reset = 1'b1;
    exp_q.delete();
    m_mode = 0;
    m_step = 0;
    @(negedge clk);
    check("rst_outs", {29'd0, sif.inc, sif.dec, sif.err}, 32'd0);
    check("rst_sync", {30'd0, dut.ab_sync}, 32'd0);
    check("rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    reset = 1'b0;
    drive(ab_after);
  endtask

  task automatic pass_seq(input logic [1:0] c0, input logic [1:0] c1,
                          input logic [1:0] c2, input logic [1:0] c3, input int n);
    hold(c0, n); hold(c1, n); hold(c2, n); hold(c3, n);
  endtask

  initial begin
    sif.a = 1'b0;
    sif.b = 1'b0;
    m_mode = 0;
    m_step = 0;
    clear_counts();

    // Entry from reset
    apply_reset(2'b00);
    clear_counts();
    hold(2'b00, 3);
    pass_seq(2'b10, 2'b11, 2'b01, 2'b00, 4);
    hold(2'b00, 4);
    check("entry_inc_count", cnt_inc, 1);
    check("entry_dec_count", cnt_dec, 0);

    // Exit
    clear_counts();
    pass_seq(2'b01, 2'b11, 2'b10, 2'b00, 4);
    hold(2'b00, 4);
    check("exit_dec_count", cnt_dec, 1);
    check("exit_inc_count", cnt_inc, 0);

    // Reversals, short and long
    clear_counts();
    pass_seq(2'b10, 2'b11, 2'b10, 2'b00, 4);
    hold(2'b00, 4);
    check("rev_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    pass_seq(2'b01, 2'b11, 2'b10, 2'b11, 3);
    pass_seq(2'b01, 2'b11, 2'b01, 2'b00, 3);
    hold(2'b00, 4);
    check("rev_pulses", cnt_inc + cnt_dec, 0);

    // Illegal sequences
    clear_counts();
    hold(2'b11, 6);
    hold(2'b00, 4);
    pass_seq(2'b10, 2'b01, 2'b01, 2'b00, 3);
    pass_seq(2'b01, 2'b11, 2'b00, 2'b00, 3);
    hold(2'b00, 4);
    check("illegal_pulses", cnt_inc + cnt_dec, 0);
    check("illegal_err_clear", {31'd0, sif.err}, 32'd0);

    // Reset in the middle of an entry
    clear_counts();
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
    apply_reset(2'b00);
    hold(2'b00, 6);
    check("rst_mid_inc", cnt_inc, 0);
    check("rst_mid_outs", {29'd0, sif.inc, sif.dec, sif.err}, 32'd0);

    // Blocked at reset release, then a long wait in a partial state
    apply_reset(2'b11);
    hold(2'b11, 5);
    hold(2'b00, 4);
    clear_counts();
    hold(2'b10, 60);
    pass_seq(2'b11, 2'b01, 2'b00, 2'b00, 2);
    hold(2'b00, 4);
    check("long_hold_inc", cnt_inc, 1);

    // Back-to-back traffic: 3 entries then 2 exits
    apply_reset(2'b00);
    clear_counts();
    repeat (3) pass_seq(2'b10, 2'b11, 2'b01, 2'b00, 1);
    repeat (2) pass_seq(2'b01, 2'b11, 2'b10, 2'b00, 1);
    hold(2'b00, 5);
    check("thru_inc_count", cnt_inc, 3);
    check("thru_dec_count", cnt_dec, 2);
    check("thru_occupancy", occupancy, 1);

    // Random sensor activity
    for (int i = 0; i < 300; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      hold(r, int'($urandom_range(1, 3)));
    end
    hold(2'b00, 6);
    check("final_state", {29'd0, dut.state_q}, {29'd0, IDLE});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
